uart_tx_arb: RTL

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_tx_arb.sv | 132 +++++++++++++
 1 files changed

// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - four-requester byte arbiter feeding a UART data register
// Round-robin grant with per-packet lock and idle timeout; divider written once after reset.
module uart_tx_arb #(
    parameter logic [31:0] DIV_INIT = 32'd868,
    parameter int          LOCK_TMO = 1024
) (
    input  logic        bus_clk,
    input  logic        bus_reset,
    input  logic [3:0]  req_valid,
    input  logic [31:0] req_data,
    input  logic [3:0]  req_last,
    output logic [3:0]  req_ready,
    output logic [3:0]  uart_div_we,
    output logic [31:0] uart_div_di,
    output logic        uart_dat_we,
    output logic [31:0] uart_dat_di,
    input  logic        uart_dat_ack,
    output logic        busy,
    output logic [1:0]  owner
);

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_SEND} state_t;

    localparam logic [15:0] TMO_LAST = 16'(LOCK_TMO - 1);

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_ptr;
    logic [1:0]  r_owner;
    logic        r_lock;
    logic [15:0] r_cnt;
    logic [7:0]  r_byte;
    logic        w_grant;
    logic [1:0]  w_win;
    logic [1:0]  w_idx;

    // Scan from the highest offset down so the requester closest to r_ptr is the last assignment.
    always_comb begin
        w_grant = 1'b0;
        w_win   = r_ptr;
        w_idx   = r_ptr;
        if (r_state == ST_IDLE && !bus_reset) begin
            if (r_lock) begin
                if (req_valid[r_owner]) begin
                    w_grant = 1'b1;
                    w_win   = r_owner;
                end
            end else begin
                for (int k = 3; k >= 0; k--) begin
                    w_idx = r_ptr + 2'(k);
                    if (req_valid[w_idx]) begin
                        w_grant = 1'b1;
                        w_win   = w_idx;
                    end
                end
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        req_ready   = 4'h0;
        uart_div_we = 4'h0;
        uart_div_di = 32'd0;
        uart_dat_we = 1'b0;
        uart_dat_di = 32'd0;
        case (r_state)
            ST_INIT: begin
                w_next = ST_IDLE;
                if (!bus_reset) begin
                    uart_div_we = 4'hF;
                    uart_div_di = DIV_INIT;
                end
            end
            ST_IDLE: begin
                if (w_grant) begin
                    req_ready[w_win] = 1'b1;
                    w_next           = ST_SEND;
                end
            end
            ST_SEND: begin
                if (!bus_reset) begin
                    uart_dat_we = 1'b1;
                    uart_dat_di = {24'd0, r_byte};
                end
                if (uart_dat_ack) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_INIT;
        endcase
    end

    always_ff @(posedge bus_clk) begin
        if (bus_reset) begin
            r_state <= ST_INIT;
            r_ptr   <= 2'd0;
            r_owner <= 2'd0;
            r_lock  <= 1'b0;
            r_cnt   <= 16'd0;
            r_byte  <= 8'd0;
        end else begin
            r_state <= w_next;
            if (w_grant) begin
                r_byte  <= req_data[{w_win, 3'b000} +: 8];
                r_owner <= w_win;
                r_cnt   <= 16'd0;
                if (req_last[w_win]) begin
                    r_lock <= 1'b0;
                    r_ptr  <= w_win + 2'd1;
                end else begin
                    r_lock <= 1'b1;
                end
            end else if (r_lock && r_state == ST_IDLE && !req_valid[r_owner]) begin
                // Owner went quiet mid-packet: release after LOCK_TMO idle cycles.
                if (r_cnt == TMO_LAST) begin
                    r_lock <= 1'b0;
                    r_cnt  <= 16'd0;
                    r_ptr  <= r_owner + 2'd1;
                end else begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end else if (!r_lock) begin
                r_cnt <= 16'd0;
            end
        end
    end

    assign busy  = bus_reset | (r_state != ST_IDLE) | r_lock;
    assign owner = r_owner;

endmodule
